sfp_expander_reader: RTL and testbench



---
 rtl/sfp_i2c_pkg.sv | 57 +++++
 rtl/i2c_rsp_timeout.sv | 34 +++
 rtl/sfp_expander_reader.sv | 169 ++++++++++++++++
 tb/tb_sfp_expander_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_i2c_pkg.sv
// Shared encodings for the SFP status-monitor I2C sequencers: command opcodes,
// abort causes, one-hot state indices and the default bus addresses.
package sfp_i2c_pkg;

    localparam logic [6:0] DEF_MUX_ADDR = 7'h74;
    localparam logic [6:0] DEF_EXP_ADDR = 7'h20;
    localparam logic [7:0] DEF_EXP_REG  = 8'h00;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'd0,
        CMD_READ  = 2'd1,
        CMD_STOP  = 2'd2
    } cmd_op_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MUX_NACK = 2'd1,
        ERR_EXP_NACK = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    // One-hot bit positions, shared with the other FMC state machines
    localparam int IDX_IDLE       = 0;
    localparam int IDX_MUX_ADR    = 1;
    localparam int IDX_MUX_DAT    = 2;
    localparam int IDX_EXP_ADRW   = 3;
    localparam int IDX_EXP_PTR    = 4;
    localparam int IDX_EXP_ADRR   = 5;
    localparam int IDX_EXP_RD     = 6;
    localparam int IDX_ABORT_STOP = 7;
    localparam int IDX_DONE       = 8;

    typedef enum logic [8:0] {
        IDLE       = 9'(1 << IDX_IDLE),
        MUX_ADR    = 9'(1 << IDX_MUX_ADR),
        MUX_DAT    = 9'(1 << IDX_MUX_DAT),
        EXP_ADRW   = 9'(1 << IDX_EXP_ADRW),
        EXP_PTR    = 9'(1 << IDX_EXP_PTR),
        EXP_ADRR   = 9'(1 << IDX_EXP_ADRR),
        EXP_RD     = 9'(1 << IDX_EXP_RD),
        ABORT_STOP = 9'(1 << IDX_ABORT_STOP),
        DONE       = 9'(1 << IDX_DONE)
    } state_t;

    // Sub-phase of every byte state: idle cycle, command offered, response awaited
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_CMD   = 2'd1,
        PH_RSP   = 2'd2
    } phase_t;

    // Build an I2C address byte from a 7-bit address and the R/W bit
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rd);
        return {addr, rd};
    endfunction

endpackage

// File: rtl/i2c_rsp_timeout.sv
// Loadable down-counter that flags a byte response which never arrived.
module i2c_rsp_timeout #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic             running_q;

    // Count down from the load value while armed; clear disarms it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (load) begin
            count_q   <= load_value;
            running_q <= 1'b1;
        end else if (clear) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (running_q && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign expired = running_q && (count_q == '0);

endmodule

// File: rtl/sfp_expander_reader.sv
// Selects an I2C mux branch, then reads one input-port register from the
// expander on that branch through a byte-level I2C master.
module sfp_expander_reader
    import sfp_i2c_pkg::*;
#(
    parameter logic [6:0]  MUX_ADDR       = DEF_MUX_ADDR,
    parameter logic [6:0]  EXP_ADDR       = DEF_EXP_ADDR,
    parameter logic [7:0]  EXP_REG        = DEF_EXP_REG,
    parameter int unsigned TIMEOUT_CYCLES = 125000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_read,
    input  logic [7:0] channel_sel,
    output logic [7:0] i2c_reg_dat,
    output logic       i2c_reg_valid,
    output logic       i2c_error,
    output logic       i2c_lines_busy,
    output logic [1:0] err_code,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    input  logic [7:0] rsp_rdata
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    // The accept cycle and the registered error cycle are both part of the budget
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 2);

    state_t    state_q, state_d, next_byte;
    phase_t    phase_q, phase_d;
    err_code_t err_q, err_d;
    logic [7:0] chan_q, chan_d, dat_q, dat_d;
    logic       valid_q, valid_d, error_q, error_d;
    logic       tmo_load, tmo_clear, tmo_expired;
    cmd_op_t    op;
    logic       start_f, stop_f, is_mux;
    logic [7:0] wdata;

    i2c_rsp_timeout #(.WIDTH(TMO_W)) u_rsp_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmo_load),
        .clear      (tmo_clear),
        .load_value (TMO_LOAD),
        .expired    (tmo_expired)
    );

    // Command fields and successor for each byte state; held while the state is held
    always_comb begin
        op        = CMD_WRITE;
        start_f   = 1'b0;
        stop_f    = 1'b0;
        wdata     = 8'h00;
        next_byte = IDLE;
        is_mux    = 1'b0;
        case (state_q)
            MUX_ADR:    begin start_f = 1'b1; wdata = addr_byte(MUX_ADDR, 1'b0); next_byte = MUX_DAT; is_mux = 1'b1; end
            MUX_DAT:    begin stop_f = 1'b1; wdata = chan_q; next_byte = EXP_ADRW; is_mux = 1'b1; end
            EXP_ADRW:   begin start_f = 1'b1; wdata = addr_byte(EXP_ADDR, 1'b0); next_byte = EXP_PTR; end
            EXP_PTR:    begin wdata = EXP_REG; next_byte = EXP_ADRR; end
            EXP_ADRR:   begin start_f = 1'b1; wdata = addr_byte(EXP_ADDR, 1'b1); next_byte = EXP_RD; end
            EXP_RD:     begin op = CMD_READ; stop_f = 1'b1; next_byte = DONE; end
            ABORT_STOP: begin op = CMD_STOP; stop_f = 1'b1; next_byte = IDLE; end
            default:    ;
        endcase
    end

    // Transaction sequencing: offer command, wait for response, advance or abort
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        err_d    = err_q;
        chan_d   = chan_q;
        dat_d    = dat_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        tmo_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_read) begin
                    state_d = MUX_ADR;
                    phase_d = PH_SETUP;
                    chan_d  = channel_sel;
                    err_d   = ERR_NONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
            end
            default: begin
                case (phase_q)
                    PH_SETUP: phase_d = PH_CMD;
                    PH_CMD: begin
                        if (cmd_ready) begin
                            phase_d  = PH_RSP;
                            tmo_load = 1'b1;
                        end
                    end
                    PH_RSP: begin
                        if (rsp_valid) begin
                            phase_d = PH_SETUP;
                            if (state_q == ABORT_STOP) begin
                                state_d = IDLE;
                                error_d = 1'b1;
                            end else if ((op == CMD_WRITE) && rsp_nack) begin
                                state_d = ABORT_STOP;
                                err_d   = is_mux ? ERR_MUX_NACK : ERR_EXP_NACK;
                            end else begin
                                state_d = next_byte;
                                if (state_q == EXP_RD) begin
                                    dat_d = rsp_rdata;
                                end
                            end
                        end else if (tmo_expired) begin
                            // Master presumed hung: no STOP is attempted
                            state_d = IDLE;
                            phase_d = PH_SETUP;
                            err_d   = ERR_TIMEOUT;
                            error_d = 1'b1;
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
        endcase
    end

    assign tmo_clear = (phase_d != PH_RSP);

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= PH_SETUP;
            err_q   <= ERR_NONE;
            chan_q  <= 8'h00;
            dat_q   <= 8'h00;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            chan_q  <= chan_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign cmd_valid      = (phase_q == PH_CMD);
    assign cmd_op         = op;
    assign cmd_start      = start_f;
    assign cmd_stop       = stop_f;
    assign cmd_wdata      = wdata;
    assign i2c_reg_dat    = dat_q;
    assign i2c_reg_valid  = valid_q;
    assign i2c_error      = error_q;
    assign err_code       = err_q;
    assign i2c_lines_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sfp_expander_reader.sv
// Self-checking bench: byte-level master model plus command/result scoreboards.
module tb_sfp_expander_reader;

    localparam int TMO = 50;
    localparam logic [7:0] MUX_W = {7'h74, 1'b0};
    localparam logic [7:0] EXP_W = {7'h20, 1'b0};
    localparam logic [7:0] EXP_R = {7'h20, 1'b1};
    localparam logic [7:0] PTR_B = 8'h00;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_read = 1'b0;
    logic [7:0] channel_sel = 8'h00;
    logic [7:0] i2c_reg_dat;
    logic       i2c_reg_valid, i2c_error, i2c_lines_busy;
    logic [1:0] err_code;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [1:0] cmd_op;
    logic       cmd_start, cmd_stop;
    logic [7:0] cmd_wdata;
    logic       rsp_valid = 1'b0;
    logic       rsp_nack = 1'b0;
    logic [7:0] rsp_rdata = 8'h00;

    sfp_expander_reader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start_read     (start_read),
        .channel_sel    (channel_sel),
        .i2c_reg_dat    (i2c_reg_dat),
        .i2c_reg_valid  (i2c_reg_valid),
        .i2c_error      (i2c_error),
        .i2c_lines_busy (i2c_lines_busy),
        .err_code       (err_code),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_nack       (rsp_nack),
        .rsp_rdata      (rsp_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] op;
        logic       st;
        logic       sp;
        logic [7:0] wd;
        bit         chk_flags;
        bit         chk_wd;
    } cmd_t;

    typedef struct {
        bit         is_err;
        logic [7:0] dat;
        logic [1:0] code;
        int         lat;
        bit         from_accept;
        int         start_cyc;
    } res_t;

    typedef struct {
        logic [7:0] chan;
        logic [7:0] rdat;
        int         stall;
        int         nack;
        int         hang;
        bit         is_err;
        logic [1:0] code;
        int         lat;
        bit         from_acc;
        bit         push_res;
    } vec_t;

    cmd_t exp_cmd[$];
    res_t exp_res[$];

    int checks = 0;
    int errors = 0;

    // Master model configuration, written only by the stimulus process
    int         stall_cycles = 0;
    int         nack_idx = -1;
    int         hang_idx = -1;
    logic [7:0] rd_data = 8'h00;

    // Master model state
    int         byte_idx = 0;
    int         stall_cnt = 0;
    int         last_accept_cyc = 0;
    bit         acc_pending = 0, cur_nack = 0, cur_hang = 0, was_valid = 0, stable_ok = 1;
    logic [11:0] held;
    logic [7:0] last_good = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Byte-level I2C master: optional stall on cmd_ready, response one cycle after accept
    always @(negedge clk) begin : master
        cmd_t c;
        rsp_valid = 1'b0;
        rsp_nack  = 1'b0;
        if (!i2c_lines_busy) byte_idx = 0;
        if (!reset_n) begin
            cmd_ready   = 1'b0;
            acc_pending = 0;
            was_valid   = 0;
            stall_cnt   = 0;
        end else begin
            if (acc_pending) begin
                acc_pending = 0;
                if (!cur_hang) begin
                    rsp_valid = 1'b1;
                    rsp_nack  = cur_nack;
                    rsp_rdata = rd_data;
                end
            end
            if (cmd_valid) begin
                if (!was_valid) begin
                    held      = {cmd_op, cmd_start, cmd_stop, cmd_wdata};
                    stable_ok = 1;
                    stall_cnt = 0;
                end else if ({cmd_op, cmd_start, cmd_stop, cmd_wdata} !== held) begin
                    stable_ok = 0;
                end
                cmd_ready = (stall_cnt >= stall_cycles);
                stall_cnt++;
                if (cmd_ready) begin
                    last_accept_cyc = cyc;
                    checkOutput("cmd_stable", 32'(stable_ok), 32'd1);
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_cmd: got op=%0d wdata=0x%0h, expected no command", cmd_op, cmd_wdata);
                    end else begin
                        c = exp_cmd.pop_front();
                        checkOutput("cmd_op", 32'(cmd_op), 32'(c.op));
                        if (c.chk_flags) begin
                            checkOutput("cmd_start", 32'(cmd_start), 32'(c.st));
                            checkOutput("cmd_stop", 32'(cmd_stop), 32'(c.sp));
                        end
                        if (c.chk_wd) checkOutput("cmd_wdata", 32'(cmd_wdata), 32'(c.wd));
                    end
                    cur_nack = (byte_idx == nack_idx);
                    cur_hang = (byte_idx == hang_idx);
                    byte_idx++;
                    acc_pending = 1;
                end
                was_valid = !cmd_ready;
            end else begin
                cmd_ready = 1'b0;
                was_valid = 0;
            end
        end
    end

    // Result monitor: pops the scoreboard on every valid or error pulse
    always @(negedge clk) begin : monitor
        res_t r;
        int   base;
        if (!reset_n) last_good = 8'h00;
        if (reset_n && (i2c_reg_valid || i2c_error)) begin
            checkOutput("valid_error_exclusive", 32'(i2c_reg_valid & i2c_error), 32'd0);
            checkOutput("busy_falls_with_pulse", 32'(i2c_lines_busy), 32'd0);
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got valid=%0b error=%0b, expected none", i2c_reg_valid, i2c_error);
            end else begin
                r = exp_res.pop_front();
                base = r.from_accept ? last_accept_cyc : r.start_cyc;
                checkOutput("result_kind", 32'(i2c_error), 32'(r.is_err));
                checkOutput("latency", 32'(cyc - base), 32'(r.lat));
                checkOutput("err_code", 32'(err_code), 32'(r.code));
                if (r.is_err) begin
                    checkOutput("dat_hold", 32'(i2c_reg_dat), 32'(last_good));
                end else begin
                    checkOutput("reg_dat", 32'(i2c_reg_dat), 32'(r.dat));
                    last_good = r.dat;
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        cmd_t bytes[6];
        res_t r;
        int   last;
        bytes[0] = '{2'd0, 1'b1, 1'b0, MUX_W,  1'b1, 1'b1};
        bytes[1] = '{2'd0, 1'b0, 1'b1, v.chan, 1'b1, 1'b1};
        bytes[2] = '{2'd0, 1'b1, 1'b0, EXP_W,  1'b1, 1'b1};
        bytes[3] = '{2'd0, 1'b0, 1'b0, PTR_B,  1'b1, 1'b1};
        bytes[4] = '{2'd0, 1'b1, 1'b0, EXP_R,  1'b1, 1'b1};
        bytes[5] = '{2'd1, 1'b0, 1'b1, 8'h00,  1'b1, 1'b0};
        stall_cycles = v.stall;
        nack_idx     = v.nack;
        hang_idx     = v.hang;
        rd_data      = v.rdat;
        last = (v.nack >= 0) ? v.nack : ((v.hang >= 0) ? v.hang : 5);
        for (int i = 0; i <= last; i++) exp_cmd.push_back(bytes[i]);
        if (v.nack >= 0) exp_cmd.push_back('{2'd2, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        start_read  = 1'b1;
        channel_sel = v.chan;
        if (v.push_res) begin
            r = '{v.is_err, v.rdat, v.code, v.lat, v.from_acc, cyc};
            exp_res.push_back(r);
        end
        @(negedge clk);
        start_read = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (exp_res.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done"}, 32'(exp_res.size()), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput({name, "_cmds_consumed"}, 32'(exp_cmd.size()), 32'd0);
        exp_cmd.delete();
        exp_res.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_reg_dat"}, 32'(i2c_reg_dat), 32'd0);
        checkOutput({tag, "_reg_valid"}, 32'(i2c_reg_valid), 32'd0);
        checkOutput({tag, "_error"}, 32'(i2c_error), 32'd0);
        checkOutput({tag, "_busy"}, 32'(i2c_lines_busy), 32'd0);
        checkOutput({tag, "_err_code"}, 32'(err_code), 32'd0);
        checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, "_cmd_fields"}, 32'({cmd_op, cmd_start, cmd_stop, cmd_wdata}), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        vec_t vecs[10];
        vec_t v;
        int   n;
        //          chan   rdat   stall nack hang  err   code  lat from_acc push
        vecs[0] = '{8'h08, 8'hA5, 0,  -1, -1, 1'b0, 2'd0, 20, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 8'h3C, 0,  -1, -1, 1'b0, 2'd0, 20, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h5A, 10, -1, -1, 1'b0, 2'd0, 80, 1'b0, 1'b1};
        vecs[3] = '{8'h04, 8'h11, 0,   2, -1, 1'b1, 2'd2, 13, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 8'h22, 0,   0, -1, 1'b1, 2'd1, 7,  1'b0, 1'b1};
        vecs[5] = '{8'h02, 8'h33, 0,   1, -1, 1'b1, 2'd1, 10, 1'b0, 1'b1};
        vecs[6] = '{8'h08, 8'h44, 0,  -1,  0, 1'b1, 2'd3, TMO, 1'b1, 1'b1};
        vecs[7] = '{8'h40, 8'h55, 2,   4, -1, 1'b1, 2'd2, 31, 1'b0, 1'b1};
        vecs[8] = '{8'h01, 8'hC3, 3,  -1, -1, 1'b0, 2'd0, 38, 1'b0, 1'b1};
        vecs[9] = '{8'h02, 8'h66, 0,  -1,  5, 1'b1, 2'd3, TMO, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            waitDone($sformatf("vec%0d", i), 400);
        end

        // A second start_read while busy must be ignored
        v = '{8'h10, 8'h77, 0, -1, -1, 1'b0, 2'd0, 20, 1'b0, 1'b1};
        applyStimulus(v);
        repeat (2) @(negedge clk);
        start_read  = 1'b1;
        channel_sel = 8'h20;
        @(negedge clk);
        start_read = 1'b0;
        waitDone("ignore_second_start", 200);
        checkOutput("ignore_second_start_idle", 32'(i2c_lines_busy), 32'd0);

        // Back-to-back: new request in the cycle right after the valid pulse
        v = '{8'h08, 8'h81, 0, -1, -1, 1'b0, 2'd0, 20, 1'b0, 1'b1};
        applyStimulus(v);
        n = 0;
        while (exp_res.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_first_done", 32'(exp_res.size()), 32'd0);
        v = '{8'h04, 8'h82, 0, -1, -1, 1'b0, 2'd0, 20, 1'b0, 1'b1};
        applyStimulus(v);
        waitDone("b2b_second", 200);

        // Reset while waiting for the EXP_RD response
        v = '{8'h08, 8'h99, 0, -1, 5, 1'b0, 2'd0, 0, 1'b0, 1'b0};
        applyStimulus(v);
        n = 0;
        while (byte_idx != 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_exp_rd", 32'(byte_idx), 32'd6);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        exp_cmd.delete();
        exp_res.delete();
        @(negedge clk);
        v = '{8'h20, 8'hE7, 0, -1, -1, 1'b0, 2'd0, 20, 1'b0, 1'b1};
        applyStimulus(v);
        waitDone("after_reset", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
